// File: rtl/dspl_arbiter.sv
// dspl_arbiter: round-robin sharing of the 8-digit 7-segment display driver
// between two requesting sources. Owners keep the display for at least
// MIN_HOLD cycles. A waiting source takes over after MAX_HOLD cycles.
// Optional macro DSPL_ARB_GAP_EN inserts GAP_CYCLES blank cycles on every
// owner exit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner, display blank, arbitrate on requests
// OWN0    | source 0 drives the display
// OWN1    | source 1 drives the display
// GAP     | (DSPL_ARB_GAP_EN only) blank handover interval, then arbitrate
`timescale 1ns/1ps

module dspl_arbiter #(
    parameter int MIN_HOLD   = 4,
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 3
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [47:0] i_src0_digits,
    input  logic [47:0] i_src1_digits,
    output logic [1:0]  o_gnt,
    output logic [5:0]  o_d1,
    output logic [5:0]  o_d2,
    output logic [5:0]  o_d3,
    output logic [5:0]  o_d4,
    output logic [5:0]  o_d5,
    output logic [5:0]  o_d6,
    output logic [5:0]  o_d7,
    output logic [5:0]  o_d8
);

    // The counter is shared by the hold timer and the handover gap.
    localparam int CNT_TOP = (MAX_HOLD > GAP_CYCLES) ? MAX_HOLD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_HOLD - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
`ifdef DSPL_ARB_GAP_EN
    localparam logic [1:0] ST_GAP  = 2'd3;
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES - 1);
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_last;
    logic [1:0]       r_gnt;
    logic [47:0]      r_digits;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_arb;
    logic             w_exit0;
    logic             w_exit1;
    logic [1:0]       w_gnt_nxt;
    logic [47:0]      w_digits_nxt;

    // Idle-style arbitration: on a tie, the source not served last wins.
    always_comb begin
        w_arb = ST_IDLE;
        if (i_req0 && i_req1) begin
            w_arb = r_last ? ST_OWN0 : ST_OWN1;
        end else if (i_req0) begin
            w_arb = ST_OWN0;
        end else if (i_req1) begin
            w_arb = ST_OWN1;
        end
    end

    // Owner exit: voluntary release after the minimum hold, or preemption by a waiter.
    always_comb begin
        w_exit0 = (!i_req0 && (r_hold_cnt >= MIN_LIM)) || (i_req1 && (r_hold_cnt == MAX_LIM));
        w_exit1 = (!i_req1 && (r_hold_cnt >= MIN_LIM)) || (i_req0 && (r_hold_cnt == MAX_LIM));
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = w_arb;
            ST_OWN0: begin
                if (!w_exit0) begin
                    w_state_nxt = ST_OWN0;
                end else begin
`ifdef DSPL_ARB_GAP_EN
                    w_state_nxt = ST_GAP;
`else
                    w_state_nxt = i_req1 ? ST_OWN1 : ST_IDLE;
`endif
                end
            end
            ST_OWN1: begin
                if (!w_exit1) begin
                    w_state_nxt = ST_OWN1;
                end else begin
`ifdef DSPL_ARB_GAP_EN
                    w_state_nxt = ST_GAP;
`else
                    w_state_nxt = i_req0 ? ST_OWN0 : ST_IDLE;
`endif
                end
            end
`ifdef DSPL_ARB_GAP_EN
            ST_GAP:  w_state_nxt = (r_hold_cnt == GAP_LIM) ? w_arb : ST_GAP;
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, hold/gap counter and last-served tracking.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_last     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_hold_cnt <= '0;
            end else if ((r_state == ST_OWN0) || (r_state == ST_OWN1)) begin
                if (r_hold_cnt < MAX_LIM) begin
                    r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                end
`ifdef DSPL_ARB_GAP_EN
            end else if (r_state == ST_GAP) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
`endif
            end
            if (w_state_nxt == ST_OWN0) begin
                r_last <= 1'b0;
            end else if (w_state_nxt == ST_OWN1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Output decode from next state so grant and digits move with the state.
    always_comb begin
        w_gnt_nxt    = 2'b00;
        w_digits_nxt = '0;
        if (w_state_nxt == ST_OWN0) begin
            w_gnt_nxt    = 2'b01;
            w_digits_nxt = i_src0_digits;
        end else if (w_state_nxt == ST_OWN1) begin
            w_gnt_nxt    = 2'b10;
            w_digits_nxt = i_src1_digits;
        end
    end

    // Registered grant and digit fields.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_gnt    <= 2'b00;
            r_digits <= '0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_digits <= w_digits_nxt;
        end
    end

    assign o_gnt = r_gnt;
    assign o_d1  = r_digits[5:0];
    assign o_d2  = r_digits[11:6];
    assign o_d3  = r_digits[17:12];
    assign o_d4  = r_digits[23:18];
    assign o_d5  = r_digits[29:24];
    assign o_d6  = r_digits[35:30];
    assign o_d7  = r_digits[41:36];
    assign o_d8  = r_digits[47:42];

endmodule
